// File: rtl/score_disp_pkg.sv
// Shared constants for the score display: segment codes, digit indices, anode helper.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package score_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] DIG_R_UNITS = 2'd0;
   localparam logic [1:0] DIG_R_TENS  = 2'd1;
   localparam logic [1:0] DIG_L_UNITS = 2'd2;
   localparam logic [1:0] DIG_L_TENS  = 2'd3;

   localparam logic [3:0] ANODE_OFF = 4'b1111;

   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/score_display_scan_if.sv
// Score inputs from the game core and the board-pin outputs of the display driver.
// master = game core / board side, slave = display driver.
interface score_display_scan_if;
   logic [3:0] Score_Left;
   logic [3:0] Score_Right;
   logic [6:0] Seg;
   logic [3:0] An;
   logic       Dp;

   modport master (output Score_Left, Score_Right, input Seg, An, Dp);
   modport slave  (input Score_Left, Score_Right, output Seg, An, Dp);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decode; codes 10-15 give a blank digit.
// Zero latency, no flow control.
module seg7_decode
   import score_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display_scan.sv
// Four-digit multiplexed score display with per-frame stability filter and increase blink.
// Pins are registered: one cycle from digit index to pins; no backpressure (free-running scan).
module score_display_scan
   import score_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 25000,
   parameter int BLINK_LEN   = 512,
   parameter int BLINK_BIT   = 6
)
(
   input  logic                 clk_lf,
   input  logic                 rst,
   score_display_scan_if.slave  disp
);

   localparam int CW     = $clog2(REFRESH_DIV);
   localparam int BW_LEN = $clog2(BLINK_LEN + 1);
   localparam int BW     = (BW_LEN > BLINK_BIT) ? BW_LEN : BLINK_BIT + 1;

   logic [CW-1:0] refresh_cnt;
   logic [1:0]    dig_idx;
   logic [3:0]    smp_l, smp_r;
   logic [3:0]    acc_l, acc_r;
   logic [3:0]    acc_l_nxt, acc_r_nxt;
   logic [BW-1:0] blink_l, blink_r;
   logic          refresh_tc, frame_tick;
   logic          blank_l, blank_r;

   logic [3:0]    side_val, units, bcd;
   logic          ge10, tens_digit, side_blank;
   logic [6:0]    seg_dec;

   function automatic logic [BW-1:0] blink_next(input logic [3:0] old_v,
                                                input logic [3:0] new_v,
                                                input logic [BW-1:0] cnt);
      if (new_v > old_v)
         return BW'(BLINK_LEN);
      else if (new_v < old_v)
         return '0;
      else if (cnt != '0)
         return cnt - 1'b1;
      else
         return cnt;
   endfunction

   assign refresh_tc = (refresh_cnt == CW'(REFRESH_DIV - 1));
   assign frame_tick = refresh_tc && (dig_idx == DIG_L_TENS);

   // A side's value is accepted only if it matched the previous frame's sample.
   assign acc_l_nxt = (frame_tick && (smp_l == disp.Score_Left))  ? disp.Score_Left  : acc_l;
   assign acc_r_nxt = (frame_tick && (smp_r == disp.Score_Right)) ? disp.Score_Right : acc_r;

   assign blank_l = (blink_l != '0) && blink_l[BLINK_BIT];
   assign blank_r = (blink_r != '0) && blink_r[BLINK_BIT];

   always_comb begin
      side_val   = dig_idx[1] ? acc_l : acc_r;
      side_blank = dig_idx[1] ? blank_l : blank_r;
      tens_digit = (dig_idx == DIG_L_TENS) || (dig_idx == DIG_R_TENS);
      ge10       = (side_val >= 4'd10);
      units      = ge10 ? (side_val - 4'd10) : side_val;
      // Tens position shows "1" or feeds a blank code to the decoder.
      bcd        = tens_digit ? (ge10 ? 4'd1 : 4'd15) : units;
   end

   seg7_decode u_dec (
      .bcd (bcd),
      .seg (seg_dec)
   );

   always_ff @(posedge clk_lf) begin
      if (rst) begin
         refresh_cnt <= '0;
         dig_idx     <= DIG_R_UNITS;
         smp_l       <= '0;
         smp_r       <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         blink_l     <= '0;
         blink_r     <= '0;
         disp.An     <= ANODE_OFF;
         disp.Seg    <= SEG_BLANK;
         disp.Dp     <= 1'b1;
      end else begin
         refresh_cnt <= refresh_tc ? '0 : refresh_cnt + 1'b1;
         if (refresh_tc)
            dig_idx <= dig_idx + 2'd1;
         if (frame_tick) begin
            smp_l   <= disp.Score_Left;
            smp_r   <= disp.Score_Right;
            acc_l   <= acc_l_nxt;
            acc_r   <= acc_r_nxt;
            blink_l <= blink_next(acc_l, acc_l_nxt, blink_l);
            blink_r <= blink_next(acc_r, acc_r_nxt, blink_r);
         end
         disp.An  <= anode_for(dig_idx);
         disp.Seg <= side_blank ? SEG_BLANK : seg_dec;
         disp.Dp  <= ~((dig_idx == DIG_L_UNITS) && !blank_l);
      end
   end

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with REFRESH_DIV=4, BLINK_LEN=8, BLINK_BIT=1 (16-cycle frames).
// Each frame is checked cycle by cycle against hand-derived digit patterns.
module tb_score_display_scan;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   score_display_scan_if bus ();

   score_display_scan #(
      .REFRESH_DIV (4),
      .BLINK_LEN   (8),
      .BLINK_BIT   (1)
   ) dut (
      .clk_lf (clk),
      .rst    (rst),
      .disp   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one full frame starting right after a frame tick; e0..e3 are digit 0..3 patterns.
   task automatic run_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic dp2);
      logic [6:0] es [4];
      logic [3:0] ea;
      logic       edp;
      int         d;
      es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
      for (int c = 0; c < 16; c++) begin
         d   = c / 4;
         ea  = ~(4'b0001 << d);
         edp = (d == 2) ? dp2 : 1'b1;
         cyc();
         chk($sformatf("%s_an_c%0d", tag, c),  32'(bus.An),  32'(ea));
         chk($sformatf("%s_seg_c%0d", tag, c), 32'(bus.Seg), 32'(es[d]));
         chk($sformatf("%s_dp_c%0d", tag, c),  32'(bus.Dp),  32'(edp));
      end
   endtask

   initial begin
      bus.Score_Left  = 4'd0;
      bus.Score_Right = 4'd0;
      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_an",  32'(bus.An),  32'h0000000F);
      chk("rst_seg", 32'(bus.Seg), 32'h0000007F);
      chk("rst_dp",  32'(bus.Dp),  32'h00000001);
      rst = 1'b0;

      // Scan order with 0/0
      run_frame("f00", S0, SB, S0, SB, 1'b0);
      run_frame("f01", S0, SB, S0, SB, 1'b0);

      // Right toggles 3/4 every frame: never accepted
      for (int f = 2; f <= 5; f++) begin
         bus.Score_Right = (f % 2 == 0) ? 4'd3 : 4'd4;
         run_frame($sformatf("f%02d", f), S0, SB, S0, SB, 1'b0);
      end
      run_frame("f06", S0, SB, S0, SB, 1'b0);
      run_frame("f07", S4, SB, S0, SB, 1'b0);

      // Right blinks after 0->4; left goes 0->3->4
      bus.Score_Left = 4'd3;
      run_frame("f08", SB, SB, S0, SB, 1'b0);
      run_frame("f09", SB, SB, S0, SB, 1'b0);
      bus.Score_Left = 4'd4;
      run_frame("f10", S4, SB, S3, SB, 1'b0);
      run_frame("f11", S4, SB, SB, SB, 1'b1);
      run_frame("f12", SB, SB, S4, SB, 1'b0);
      run_frame("f13", SB, SB, SB, SB, 1'b1);
      run_frame("f14", S4, SB, SB, SB, 1'b1);
      run_frame("f15", S4, SB, S4, SB, 1'b0);
      run_frame("f16", S4, SB, S4, SB, 1'b0);
      run_frame("f17", S4, SB, SB, SB, 1'b1);
      run_frame("f18", S4, SB, SB, SB, 1'b1);
      run_frame("f19", S4, SB, S4, SB, 1'b0);

      // Left 4->5 starts a blink, then 5->0 cancels it
      bus.Score_Left = 4'd5;
      run_frame("f20", S4, SB, S4, SB, 1'b0);
      run_frame("f21", S4, SB, S4, SB, 1'b0);
      bus.Score_Left = 4'd0;
      run_frame("f22", S4, SB, S5, SB, 1'b0);
      run_frame("f23", S4, SB, SB, SB, 1'b1);
      run_frame("f24", S4, SB, S0, SB, 1'b0);

      // Decode 12 / 7
      bus.Score_Left  = 4'd12;
      bus.Score_Right = 4'd7;
      run_frame("f25", S4, SB, S0, SB, 1'b0);
      run_frame("f26", S4, SB, S0, SB, 1'b0);
      run_frame("f27", S7, SB, S2, S1, 1'b0);

      // 9 / 9: left decrease cancels, right increase restarts
      bus.Score_Left  = 4'd9;
      bus.Score_Right = 4'd9;
      run_frame("f28", SB, SB, SB, SB, 1'b1);
      run_frame("f29", SB, SB, SB, SB, 1'b1);
      run_frame("f30", S9, SB, S9, SB, 1'b0);

      // Reset in the middle of a blinking frame
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      chk("mid_rst_an",  32'(bus.An),  32'h0000000F);
      chk("mid_rst_seg", 32'(bus.Seg), 32'h0000007F);
      chk("mid_rst_dp",  32'(bus.Dp),  32'h00000001);
      cyc();
      chk("mid_rst_an2", 32'(bus.An),  32'h0000000F);
      rst = 1'b0;
      run_frame("r00", S0, SB, S0, SB, 1'b0);
      run_frame("r01", S0, SB, S0, SB, 1'b0);
      run_frame("r02", S9, SB, S9, SB, 1'b0);
      run_frame("r03", SB, SB, SB, SB, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
